aud_player_stereo: RTL
======================

Name: aud_player_stereo

Overview:
- Parametrised stereo I2S-family DAC serializer, successor to the single-channel 16-bit player.
- Accepts left/right sample pairs through a valid/ready handshake into a one-deep pair buffer.
- Serializes both channels MSB-first on o_aud_dacdat, framed by the codec-mastered LRCK, in I2S or right-justified mode.
- Sits between the audio datapath (recorder/DSP) and the WM8731 DAC pin, clocked by codec BCLK.

Parameters:
- DATA_W, 16: sample width per channel, 8..32.
- SLOT_W, 32: BCLK cycles per LRCK half-frame; must be >= DATA_W.
- MODE, 0: 0 = I2S (MSB one BCLK after LRCK edge); 1 = right-justified (LSB in last slot bit).

Ports:
- i_bclk  in  1  codec bit clock; all logic on posedge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_daclrck  in  1  codec LRCK; low = left, high = right; synchronous to i_bclk.
- i_en  in  1  playback enable.
- i_valid  in  1  sample pair valid.
- o_ready  out  1  pair buffer empty, can accept.
- i_l_data  in  DATA_W  left sample, two's complement.
- i_r_data  in  DATA_W  right sample.
- o_aud_dacdat  out  1  serial DAC data, registered.
- o_underrun  out  1  one-cycle pulse: frame started with empty buffer.

Behaviour:
- Reset: o_aud_dacdat=0, o_ready=0, o_underrun=0, state IDLE, buffer empty, shift/right registers 0, lrck_q=0, counter=SLOT_W-1.
- Edge detect: posedge k is an edge when i_daclrck != lrck_q. Falling = left start; rising = right start.
- Counter: width $clog2(SLOT_W)+1. Cleared to 0 at edge posedge k; increments each posedge; saturates at SLOT_W-1.
- Handshake:
  - o_ready = (state != IDLE) && buffer empty.
  - Transfer on posedge with i_valid && o_ready; buffer becomes full and o_ready drops the next cycle.
  - Data on i_l_data/i_r_data is ignored when not ready.
- States:
  - IDLE: output 0. i_en=1 -> WAIT.
  - WAIT: await a falling edge -> LEFT.
  - LEFT: on rising edge -> RIGHT.
  - RIGHT: on falling edge -> LEFT.
- Frame load at each falling edge while in WAIT/RIGHT:
  - Buffer full: shift <= left sample, right_hold <= right sample, buffer empties (o_ready=1 from k+1).
  - Buffer empty: shift and right_hold <= 0; o_underrun=1 for the cycle after k.
  - Transfer and load on the same posedge with buffer empty: counted as underrun; the accepted pair plays next frame.
- Rising edge: shift <= right_hold.
- MODE=0: the bit driven after posedge k+n is sample bit DATA_W-1-n, for n in 0..DATA_W-1; 0 otherwise.
- MODE=1: 0 after posedges k..k+SLOT_W-DATA_W-1; MSB after k+SLOT_W-DATA_W; LSB after k+SLOT_W-1.
- Short half-frame (edge before SLOT_W): the new edge restarts the counter; remaining bits are truncated.
- Long half-frame: output 0 once bits are exhausted.
- i_en=0 mid-stream: the current half-frame completes; at the next edge go IDLE, clear the buffer, output 0. Re-enabling re-enters WAIT, so the left channel is always first.
- Async reset mid-frame: immediate return to reset values.
- No rounding or width conversion; samples are sent verbatim.

Optional Feature:
- Macro AUD_PLAYER_STEREO_HOLD_EN.
- Defined: an underrun replays the last successfully played pair instead of zeros, avoiding clicks; o_underrun still pulses.
- Undefined: an underrun outputs zeros for both channels.

Decomposition:
- Package aud_pkg: state enum (IDLE, WAIT, LEFT, RIGHT), MODE_I2S=0 and MODE_RJ=1 constants, lrck edge-type enum.
- One sub-module, aud_shift_tx: DATA_W shift register plus slot counter and mode-dependent start offset, loaded by the parent FSM.
- FSM, buffer and handshake live in the top.

Test Plan:
- DATA_W=16, SLOT_W=32, MODE=0: pair L=16'hA5C3, R=16'h0F0F accepted before the falling edge -> left bits A5C3 MSB-first from k+0..k+15, then 16 zeros; right 0F0F after the rising edge.
- MODE=1, DATA_W=24, SLOT_W=32: L=24'h800001 -> 8 zeros, then 1, 22 zeros, 1; LSB on the cycle before the rising edge.
- No pair supplied at a falling edge -> o_underrun pulses exactly once, output 0 for 64 bits. With HOLD_EN, the previous pair 1234/5678 repeats.
- i_valid held high continuously -> exactly one pair accepted per frame; o_ready high one cycle after each falling edge.
- Shortened half-frame of 12 BCLKs with DATA_W=16 -> 12 MSBs sent, counter restarts cleanly, next channel is correct.
- i_en dropped mid-left -> left finishes, IDLE at the next edge, o_ready=0; reset asserted mid-right -> o_aud_dacdat=0 immediately.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared types for the stereo DAC player: FSM states, serializer modes, LRCK edge classification.
package aud_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, LEFT, RIGHT} state_t;

  typedef enum logic [1:0] {EDGE_NONE, EDGE_FALL, EDGE_RISE} lrck_edge_t;

  localparam int MODE_I2S = 0;
  localparam int MODE_RJ  = 1;

  function automatic lrck_edge_t lrck_edge(input logic cur, input logic prev);
    if (cur == prev) return EDGE_NONE;
    return cur ? EDGE_RISE : EDGE_FALL;
  endfunction

endpackage

// File: rtl/aud_player_stereo_if.sv
// Sample-pair handshake between the audio datapath (master) and the stereo player (slave).
interface aud_player_stereo_if #(
  parameter int DATA_W = 16
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] l_data;
  logic [DATA_W-1:0] r_data;

  modport master (output valid, output l_data, output r_data, input ready);
  modport slave  (input valid, input l_data, input r_data, output ready);

endinterface

// File: rtl/aud_shift_tx.sv
// One-channel MSB-first serializer with slot counter; a start pulse restarts the slot and loads a sample.
module aud_shift_tx
  import aud_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 32,
  parameter int MODE   = MODE_I2S
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_dat
);

  localparam int          CNT_W  = $clog2(SLOT_W) + 1;
  localparam int unsigned OFFSET = (MODE == MODE_RJ) ? SLOT_W - DATA_W : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W - 1);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;

  // o_dat is registered, so the first bit is taken straight from i_data at the start edge;
  // once shreg drains, zeros shift out for any long half-frame.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt   <= CNT_MAX;
      shreg <= '0;
      o_dat <= 1'b0;
    end else if (i_start) begin
      cnt <= '0;
      if (OFFSET == 0) begin
        o_dat <= i_data[DATA_W-1];
        shreg <= i_data << 1;
      end else begin
        o_dat <= 1'b0;
        shreg <= i_data;
      end
    end else begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (32'(cnt) + 32'd1 >= OFFSET) begin
        o_dat <= shreg[DATA_W-1];
        shreg <= shreg << 1;
      end else begin
        o_dat <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aud_player_stereo.sv
// Stereo I2S / right-justified DAC player: pair buffer, LRCK-framed FSM and serializer.
// Optional AUD_PLAYER_STEREO_HOLD_EN: on underrun replay the last played pair instead of zeros.
module aud_player_stereo
  import aud_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 32,
  parameter int MODE   = MODE_I2S
) (
  input  logic                i_bclk,
  input  logic                i_rst_n,
  input  logic                i_daclrck,
  input  logic                i_en,
  aud_player_stereo_if.slave  s_pair,
  output logic                o_aud_dacdat,
  output logic                o_underrun
);

  state_t            state;
  lrck_edge_t        lrck_ev;
  logic              lrck_q;
  logic              buf_full;
  logic              xfer;
  logic              frame_load;
  logic              rise_load;
  logic              tx_start;
  logic [DATA_W-1:0] l_buf;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] right_hold;
  logic [DATA_W-1:0] fill_l;
  logic [DATA_W-1:0] fill_r;
  logic [DATA_W-1:0] tx_data;

`ifdef AUD_PLAYER_STEREO_HOLD_EN
  logic [DATA_W-1:0] last_l;
  logic [DATA_W-1:0] last_r;

  assign fill_l = last_l;
  assign fill_r = last_r;
`else
  assign fill_l = '0;
  assign fill_r = '0;
`endif

  assign lrck_ev      = lrck_edge(i_daclrck, lrck_q);
  assign s_pair.ready = (state != IDLE) && !buf_full;
  assign xfer         = s_pair.valid && s_pair.ready;
  assign frame_load   = (lrck_ev == EDGE_FALL) && i_en && (state == WAIT || state == RIGHT);
  assign rise_load    = (lrck_ev == EDGE_RISE) && i_en && (state == LEFT);

  // Every LRCK edge restarts the serializer slot; edges that carry no sample load zeros.
  always_comb begin
    tx_start = (lrck_ev != EDGE_NONE);
    tx_data  = '0;
    if (frame_load)     tx_data = buf_full ? l_buf : fill_l;
    else if (rise_load) tx_data = right_hold;
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      lrck_q     <= 1'b0;
      buf_full   <= 1'b0;
      l_buf      <= '0;
      r_buf      <= '0;
      right_hold <= '0;
      o_underrun <= 1'b0;
`ifdef AUD_PLAYER_STEREO_HOLD_EN
      last_l     <= '0;
      last_r     <= '0;
`endif
    end else begin
      lrck_q     <= i_daclrck;
      o_underrun <= 1'b0;
      if (xfer) begin
        buf_full <= 1'b1;
        l_buf    <= s_pair.l_data;
        r_buf    <= s_pair.r_data;
      end
      case (state)
        IDLE: if (i_en) state <= WAIT;
        default: begin
          if (lrck_ev != EDGE_NONE) begin
            if (!i_en) begin
              state      <= IDLE;
              buf_full   <= 1'b0;
              right_hold <= '0;
            end else if (frame_load) begin
              state <= LEFT;
              // A pair accepted on an underrun edge keeps buf_full set and plays next frame.
              if (buf_full) begin
                right_hold <= r_buf;
                buf_full   <= 1'b0;
`ifdef AUD_PLAYER_STEREO_HOLD_EN
                last_l     <= l_buf;
                last_r     <= r_buf;
`endif
              end else begin
                right_hold <= fill_r;
                o_underrun <= 1'b1;
              end
            end else if (rise_load) begin
              state <= RIGHT;
            end
          end
        end
      endcase
    end
  end

  aud_shift_tx #(
    .DATA_W (DATA_W),
    .SLOT_W (SLOT_W),
    .MODE   (MODE)
  ) u_tx (
    .i_bclk  (i_bclk),
    .i_rst_n (i_rst_n),
    .i_start (tx_start),
    .i_data  (tx_data),
    .o_dat   (o_aud_dacdat)
  );

endmodule
